exp_bias_adjust: RTL and testbench
==================================

EXP_BIAS_ADJUST -- requirements
Module: exp_bias_adjust

Interface
REQ-001 Parameter W, default 11, exponent width in bits.
REQ-002 Parameter BIAS, default 1023, exponent bias subtracted from the raw sum.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_in_valid  input  1  upstream holds a valid exponent sum this cycle.
REQ-006 io_in_ready  output  1  block accepts the input this cycle.
REQ-007 io_in_s  input  W  exponent sum bits from the upstream adder.
REQ-008 io_in_c  input  1  carry-out of the upstream adder, bit W of the raw sum.
REQ-009 io_in_norm  input  1  mantissa-normalisation increment, value 0 or 1.
REQ-010 io_out_valid  output  1  io_out_e/ovf/unf are valid this cycle.
REQ-011 io_out_ready  input  1  downstream accepts the output this cycle.
REQ-012 io_out_e  output  W  biased result exponent.
REQ-013 io_out_ovf  output  1  result exponent overflowed (>= 2^W-1).
REQ-014 io_out_unf  output  1  result exponent underflowed (<= 0).

Function
REQ-015 The block SHALL form raw = {io_in_c, io_in_s} + io_in_norm - BIAS as a W+2-bit signed value (range -1023..3073 at defaults); no intermediate truncation.
REQ-016 The block SHALL be a 2-stage pipeline: stage 1 registers raw plus a valid bit; stage 2 registers io_out_e, io_out_ovf, io_out_unf plus io_out_valid.
REQ-017 Global advance: en = !io_out_valid || io_out_ready; io_in_ready SHALL equal en (combinational, no dependence on io_in_valid).
REQ-018 Transfer in SHALL occur when io_in_valid && io_in_ready; transfer out when io_out_valid && io_out_ready.
REQ-019 When en=1, stage 1 SHALL load (io_in_valid, raw) and stage 2 SHALL load stage 1 contents; when en=0, both stages SHALL hold.
REQ-020 Latency SHALL be 2 cycles from input transfer to io_out_valid with io_out_ready held high; throughput SHALL be 1 result per cycle.
REQ-021 Simultaneous input and output transfer with both stages full SHALL advance all stages with no bubble and no loss.
REQ-022 io_out_ovf SHALL be 1 iff raw >= 2^W-1; io_out_unf SHALL be 1 iff raw <= 0; both never 1 together.
REQ-023 While io_out_valid=1 and io_out_ready=0, io_out_e/ovf/unf SHALL remain stable.
REQ-024 Bubbles (stage valid=0) SHALL propagate without asserting io_out_valid; their data contents are don't-care.

Reset
REQ-025 On reset assertion, both valid bits and all data registers SHALL clear to 0 immediately (asynchronous); io_out_valid, io_out_e, io_out_ovf, io_out_unf SHALL read 0.
REQ-026 Reset mid-operation SHALL discard in-flight data; the first post-reset transfer behaves as from empty.
REQ-027 io_in_ready SHALL be 1 during and after reset (pipeline empty).

Configuration
REQ-028 Macro EXP_BIAS_ADJUST_SAT_EN: when defined, io_out_e SHALL be 2^W-1 on overflow and 0 on underflow, else raw[W-1:0].
REQ-029 Without EXP_BIAS_ADJUST_SAT_EN, io_out_e SHALL be raw[W-1:0] (wrap) in all cases; flags are unaffected.

Structure
REQ-030 Shared package SHALL hold EXP_W (11), EXP_BIAS (1023), EXP_MAX (2^W-1), and the stage-1 record typedef (valid, raw).
REQ-031 Stage 2 flag/saturation logic SHALL be one sub-module exp_range_check (raw in; e, ovf, unf out); no other sub-modules.

Verification
REQ-032 c=0, s=0x400, norm=0, out_ready=1 -> 2 cycles later e=0x001, ovf=0, unf=0.
REQ-033 c=0, s=0x3FF, norm=0 -> e=0x000, unf=1; c=0, s=0x3FF, norm=1 -> e=0x001, unf=0.
REQ-034 c=1, s=0x7FF, norm=0 (raw=3072) -> ovf=1; e=0x7FF with SAT_EN, e=0x400 without.
REQ-035 Back-to-back 8 inputs, out_ready toggling 1,0,0,1,... -> all 8 results in order, none dropped or duplicated; io_in_ready=0 exactly when out_valid=1 and out_ready=0; outputs stable while stalled.
REQ-036 Reset asserted asynchronously with both stages full -> out_valid=0, e=0 before next edge; next input emerges after 2 cycles.

Source files
------------

// File: rtl/exp_bias_adjust_pkg.sv
// exp_bias_adjust_pkg
// Shared definitions for the exponent bias-adjust slice.
//   EXP_W    : default exponent width
//   EXP_BIAS : default exponent bias
//   EXP_MAX  : largest representable exponent code (all ones)
//   stage1_t : stage-1 record (valid bit plus the signed raw exponent)
package exp_bias_adjust_pkg;

    localparam int EXP_W    = 11;
    localparam int EXP_BIAS = 1023;
    localparam int EXP_MAX  = (1 << EXP_W) - 1;

    typedef struct packed {
        logic                    valid;
        logic signed [EXP_W+1:0] raw;
    } stage1_t;

endpackage

// File: rtl/exp_bias_adjust_if.sv
// exp_bias_adjust_if
// Valid/ready handshake bundle between the exponent adder, the bias-adjust
// block and its consumer.
//   io_in_valid / io_in_ready : input handshake
//   io_in_s, io_in_c          : exponent sum and its carry-out (bit W)
//   io_in_norm                : mantissa-normalisation increment (0/1)
//   io_out_valid / io_out_ready : output handshake
//   io_out_e                  : biased result exponent
//   io_out_ovf, io_out_unf    : overflow / underflow flags
// Modports: master = upstream/downstream side (testbench), slave = block.
interface exp_bias_adjust_if
    import exp_bias_adjust_pkg::*;
#(
    parameter int W = EXP_W
);
    logic         io_in_valid;
    logic         io_in_ready;
    logic [W-1:0] io_in_s;
    logic         io_in_c;
    logic         io_in_norm;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [W-1:0] io_out_e;
    logic         io_out_ovf;
    logic         io_out_unf;

    modport master (
        output io_in_valid, io_in_s, io_in_c, io_in_norm, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_e, io_out_ovf, io_out_unf
    );

    modport slave (
        input  io_in_valid, io_in_s, io_in_c, io_in_norm, io_out_ready,
        output io_in_ready, io_out_valid, io_out_e, io_out_ovf, io_out_unf
    );
endinterface

// File: rtl/exp_bias_adjust_range_check.sv
// exp_range_check
// Combinational range classification of a signed raw exponent.
//   raw : W+2-bit signed exponent after bias removal
//   e   : result exponent code (wrapped, or clamped when saturation is on)
//   ovf : raw >= 2^W-1
//   unf : raw <= 0
// Optional feature macro: EXP_BIAS_ADJUST_SAT_EN clamps e to all-ones on
// overflow and to zero on underflow; otherwise e is raw[W-1:0].
module exp_range_check
    import exp_bias_adjust_pkg::*;
#(
    parameter int W = EXP_W
) (
    input  logic signed [W+1:0] raw,
    output logic        [W-1:0] e,
    output logic                ovf,
    output logic                unf
);
    localparam logic signed [W+1:0] MAX_S  = {2'b00, {W{1'b1}}};
    localparam logic signed [W+1:0] ZERO_S = '0;

    // Both operands are signed so negative raw values compare correctly.
    assign ovf = (raw >= MAX_S);
    assign unf = (raw <= ZERO_S);

`ifdef EXP_BIAS_ADJUST_SAT_EN
    function automatic logic [W-1:0] sat_exp(input logic signed [W+1:0] r,
                                             input logic o, input logic u);
        logic [W-1:0] res;
        res = r[W-1:0];
        if (o) res = {W{1'b1}};
        if (u) res = '0;
        return res;
    endfunction

    assign e = sat_exp(raw, ovf, unf);
`else
    assign e = raw[W-1:0];
`endif
endmodule

// File: rtl/exp_bias_adjust.sv
// exp_bias_adjust
// Two-stage pipeline that removes the exponent bias from an adder result,
// adds the normalisation increment and flags overflow/underflow.
//   clock : rising-edge clock
//   reset : asynchronous, active-high; empties the pipeline and zeroes data
//   bus   : exp_bias_adjust_if.slave (input and output valid/ready streams)
// Parameters: W (exponent width), BIAS (exponent bias).
// Optional feature macro: EXP_BIAS_ADJUST_SAT_EN (saturating exponent, see
// exp_range_check).
// Flow control is a single global enable: both stages advance together
// whenever the output register is empty or being consumed.
module exp_bias_adjust
    import exp_bias_adjust_pkg::*;
#(
    parameter int W    = EXP_W,
    parameter int BIAS = EXP_BIAS
) (
    input  logic              clock,
    input  logic              reset,
    exp_bias_adjust_if.slave  bus
);
    localparam int RW = W + 2;
    localparam logic signed [RW-1:0] BIAS_S = RW'(BIAS);

    logic                 en;
    logic signed [RW-1:0] sum_s;
    logic signed [RW-1:0] norm_s;
    logic signed [RW-1:0] raw_in;

    logic                 vld_p1;
    logic signed [RW-1:0] raw_p1;

    logic         [W-1:0] e_chk;
    logic                 ovf_chk;
    logic                 unf_chk;

    logic                 vld_p2;
    logic         [W-1:0] e_p2;
    logic                 ovf_p2;
    logic                 unf_p2;

    assign en = !vld_p2 || bus.io_out_ready;

    // Full W+2-bit signed arithmetic: {c,s} spans W+1 bits and the bias can
    // drive the result negative, so one extra sign bit avoids any truncation.
    assign sum_s  = {1'b0, bus.io_in_c, bus.io_in_s};
    assign norm_s = {{(RW-1){1'b0}}, bus.io_in_norm};
    assign raw_in = sum_s + norm_s - BIAS_S;

    // ---- stage 1: raw exponent ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            raw_p1 <= '0;
        end else if (en) begin
            vld_p1 <= bus.io_in_valid;
            raw_p1 <= raw_in;
        end
    end

    exp_range_check #(.W(W)) u_range_check (
        .raw (raw_p1),
        .e   (e_chk),
        .ovf (ovf_chk),
        .unf (unf_chk)
    );

    // ---- stage 2: result exponent and flags ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            e_p2   <= '0;
            ovf_p2 <= 1'b0;
            unf_p2 <= 1'b0;
        end else if (en) begin
            vld_p2 <= vld_p1;
            e_p2   <= e_chk;
            ovf_p2 <= ovf_chk;
            unf_p2 <= unf_chk;
        end
    end

    assign bus.io_in_ready  = en;
    assign bus.io_out_valid = vld_p2;
    assign bus.io_out_e     = e_p2;
    assign bus.io_out_ovf   = ovf_p2;
    assign bus.io_out_unf   = unf_p2;
endmodule

// File: tb/tb_exp_bias_adjust.sv
// tb_exp_bias_adjust
// Scoreboard bench for exp_bias_adjust: the driver issues directed vectors,
// a negedge monitor pushes the hand-computed expectation of every accepted
// input and pops/compares on every output transfer.
module tb_exp_bias_adjust;

    typedef struct {
        logic        c;
        logic [10:0] s;
        logic        norm;
        logic [10:0] e_wrap;
        logic [10:0] e_sat;
        logic        ovf;
        logic        unf;
    } vec_t;

    typedef struct {
        logic [10:0] e;
        logic        ovf;
        logic        unf;
        int          idx;
    } exp_t;

    logic clock;
    logic reset;

    exp_bias_adjust_if #(.W(11)) bus ();

    exp_bias_adjust #(.W(11), .BIAS(1023)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    vec_t  vec [12];
    exp_t  sb [$];
    exp_t  got;
    int    n_total = 0;
    int    n_pass  = 0;
    int    n_in    = 0;
    int    n_out   = 0;
    int    cur_idx = 0;
    logic  done_c  = 1'b0;

    logic        hold_vld = 1'b0;
    logic [10:0] hold_e;
    logic        hold_ovf;
    logic        hold_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic exp_t expect_of(input int idx);
        exp_t x;
`ifdef EXP_BIAS_ADJUST_SAT_EN
        x.e = vec[idx].e_sat;
`else
        x.e = vec[idx].e_wrap;
`endif
        x.ovf = vec[idx].ovf;
        x.unf = vec[idx].unf;
        x.idx = idx;
        return x;
    endfunction

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (reset) begin
            hold_vld = 1'b0;
        end else begin
            chk("in_ready", {31'd0, bus.io_in_ready},
                {31'd0, !(bus.io_out_valid && !bus.io_out_ready)});
            if (hold_vld) begin
                chk("stall_valid", {31'd0, bus.io_out_valid}, 32'd1);
                chk("stall_e", {21'd0, bus.io_out_e}, {21'd0, hold_e});
                chk("stall_ovf", {31'd0, bus.io_out_ovf}, {31'd0, hold_ovf});
                chk("stall_unf", {31'd0, bus.io_out_unf}, {31'd0, hold_unf});
            end
            if (bus.io_out_valid && bus.io_out_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got e=%0h with nothing pending, required no output",
                             bus.io_out_e);
                end else begin
                    got = sb.pop_front();
                    chk($sformatf("e[v%0d]", got.idx), {21'd0, bus.io_out_e}, {21'd0, got.e});
                    chk($sformatf("ovf[v%0d]", got.idx), {31'd0, bus.io_out_ovf}, {31'd0, got.ovf});
                    chk($sformatf("unf[v%0d]", got.idx), {31'd0, bus.io_out_unf}, {31'd0, got.unf});
                    n_out++;
                end
            end
            hold_vld = bus.io_out_valid && !bus.io_out_ready;
            hold_e   = bus.io_out_e;
            hold_ovf = bus.io_out_ovf;
            hold_unf = bus.io_out_unf;
            if (bus.io_in_valid && bus.io_in_ready) begin
                sb.push_back(expect_of(cur_idx));
                n_in++;
            end
        end
    end

    // Present vector idx and return #1 after the edge that accepts it.
    task automatic send(input int idx);
        cur_idx         = idx;
        bus.io_in_c     = vec[idx].c;
        bus.io_in_s     = vec[idx].s;
        bus.io_in_norm  = vec[idx].norm;
        bus.io_in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (bus.io_in_ready) begin
                @(posedge clock);
                #1;
                return;
            end
        end
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Empty pipeline, out_ready high: output appears two cycles after input.
    task automatic latency_check(input int idx);
        send(idx);
        bus.io_in_valid = 1'b0;
        chk($sformatf("lat_early[v%0d]", idx), {31'd0, bus.io_out_valid}, 32'd0);
        @(posedge clock);
        #1;
        chk($sformatf("lat_2cyc[v%0d]", idx), {31'd0, bus.io_out_valid}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clock);
        #1;
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        //          c     s        norm  e_wrap   e_sat    ovf   unf
        vec[0]  = '{1'b0, 11'h400, 1'b0, 11'h001, 11'h001, 1'b0, 1'b0}; // raw 1
        vec[1]  = '{1'b0, 11'h3FF, 1'b0, 11'h000, 11'h000, 1'b0, 1'b1}; // raw 0
        vec[2]  = '{1'b0, 11'h3FF, 1'b1, 11'h001, 11'h001, 1'b0, 1'b0}; // raw 1
        vec[3]  = '{1'b1, 11'h7FF, 1'b0, 11'h400, 11'h7FF, 1'b1, 1'b0}; // raw 3072
        vec[4]  = '{1'b0, 11'h000, 1'b0, 11'h401, 11'h000, 1'b0, 1'b1}; // raw -1023
        vec[5]  = '{1'b1, 11'h7FF, 1'b1, 11'h401, 11'h7FF, 1'b1, 1'b0}; // raw 3073
        vec[6]  = '{1'b1, 11'h3FD, 1'b1, 11'h7FF, 11'h7FF, 1'b1, 1'b0}; // raw 2047
        vec[7]  = '{1'b1, 11'h3FD, 1'b0, 11'h7FE, 11'h7FE, 1'b0, 1'b0}; // raw 2046
        vec[8]  = '{1'b0, 11'h7FF, 1'b0, 11'h400, 11'h400, 1'b0, 1'b0}; // raw 1024
        vec[9]  = '{1'b0, 11'h3FE, 1'b1, 11'h000, 11'h000, 1'b0, 1'b1}; // raw 0
        vec[10] = '{1'b0, 11'h3FE, 1'b0, 11'h7FF, 11'h000, 1'b0, 1'b1}; // raw -1
        vec[11] = '{1'b1, 11'h000, 1'b0, 11'h401, 11'h401, 1'b0, 1'b0}; // raw 1025

        reset            = 1'b1;
        bus.io_in_valid  = 1'b0;
        bus.io_in_s      = '0;
        bus.io_in_c      = 1'b0;
        bus.io_in_norm   = 1'b0;
        bus.io_out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_out_valid", {31'd0, bus.io_out_valid}, 32'd0);
        chk("rst_out_e", {21'd0, bus.io_out_e}, 32'd0);
        chk("rst_out_ovf", {31'd0, bus.io_out_ovf}, 32'd0);
        chk("rst_out_unf", {31'd0, bus.io_out_unf}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.io_in_ready}, 32'd1);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Single transactions with latency check
        for (int i = 0; i < 4; i++) latency_check(i);
        drain();

        // Back-to-back stream with out_ready toggling 1,0,0,1
        fork
            begin
                for (int i = 0; i < 12; i++) send(i);
                bus.io_in_valid = 1'b0;
                done_c = 1'b1;
            end
            begin
                for (int i = 0; i < 400 && !done_c; i++) begin
                    bus.io_out_ready = pat[i % 4];
                    @(posedge clock);
                    #1;
                end
            end
        join
        bus.io_out_ready = 1'b1;
        drain();
        chk("stream_count", n_out, n_in);

        // Asynchronous reset with both stages full
        send(0);
        send(1);
        bus.io_in_valid = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("async_rst_valid", {31'd0, bus.io_out_valid}, 32'd0);
        chk("async_rst_e", {21'd0, bus.io_out_e}, 32'd0);
        chk("async_rst_ovf", {31'd0, bus.io_out_ovf}, 32'd0);
        chk("async_rst_in_ready", {31'd0, bus.io_in_ready}, 32'd1);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_rst_empty", {31'd0, bus.io_out_valid}, 32'd0);
        latency_check(3);
        drain();
        repeat (3) @(posedge clock);
        #1;
        chk("final_queue", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
